// File: rtl/sel_scan_pkg.sv
// rtl/sel_scan_pkg.sv - shared types and sizes for the channel scan sequencer
package sel_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

endpackage

// File: rtl/dwell_cnt.sv
// rtl/dwell_cnt.sv - loadable down-counter timing how long each channel is held
import sel_scan_pkg::*;

module dwell_cnt #(
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sel_scan_ctrl.sv
// rtl/sel_scan_ctrl.sv - steps the mux select through all channels and snapshots Y
// Optional SEL_SCAN_CHG_DET_EN adds chg: sweep result differs from the previous sweep.
import sel_scan_pkg::*;

module sel_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int W     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               cont,
  input  logic [W-1:0]       Y,
  output logic [SEL_W-1:0]   S,
  output logic               EN,
  output logic [NCH*W-1:0]   snap,
  output logic               valid,
`ifdef SEL_SCAN_CHG_DET_EN
  output logic               chg,
`endif
  output logic               busy
);

  localparam logic [CNT_W-1:0] LP_RELOAD = CNT_W'(DWELL - 1);

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [NCH*W-1:0]   r_snap, w_snap_cap;
  logic               r_valid;
  logic               w_load, w_dec, w_cap, w_last, w_zero;

  dwell_cnt #(.CW(CNT_W)) u_dwell_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (LP_RELOAD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // abort wins over a capture landing on the same edge
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_cap       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        w_sel_nxt = '0;
        if (start) begin
          w_state_nxt = SCAN;
          w_load      = 1'b1;
        end
      end
      SCAN: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_sel_nxt   = '0;
        end else if (!w_zero) begin
          w_dec = 1'b1;
        end else begin
          w_cap = 1'b1;
          if (r_sel != SEL_W'(NCH - 1)) begin
            w_sel_nxt = r_sel + 1'b1;
            w_load    = 1'b1;
          end else begin
            w_last    = 1'b1;
            w_sel_nxt = '0;
            if (cont) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    w_snap_cap                 = r_snap;
    w_snap_cap[r_sel * W +: W] = Y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_snap  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_last;
      if (w_cap) begin
        r_snap <= w_snap_cap;
      end
    end
  end

`ifdef SEL_SCAN_CHG_DET_EN
  logic [NCH*W-1:0] r_prev;
  logic             r_chg;

  // shadow only follows completed sweeps, so aborted partial data never lands here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_chg  <= 1'b0;
    end else begin
      r_chg <= 1'b0;
      if (w_last) begin
        r_prev <= w_snap_cap;
        r_chg  <= (w_snap_cap != r_prev);
      end
    end
  end

  assign chg = r_chg;
`endif

  assign S     = r_sel;
  assign EN    = (r_state == SCAN);
  assign busy  = (r_state == SCAN);
  assign snap  = r_snap;
  assign valid = r_valid;

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// tb/tb_sel_scan_ctrl.sv - randomized bench for sel_scan_ctrl at DWELL=4 and DWELL=1
module tb_sel_scan_ctrl;

  logic clk = 1'b0;
  logic rst, start, abort, cont;
  logic [1:0] ymap [4];

  logic [1:0] y_a, y_b, s_a, s_b;
  logic       en_a, en_b, valid_a, valid_b, busy_a, busy_b;
  logic [7:0] snap_a, snap_b;
`ifdef SEL_SCAN_CHG_DET_EN
  logic       chg_a, chg_b;
`endif

  int total = 0;
  int bad   = 0;
  int nval_a = 0;
  int nval_b = 0;

  always #5 clk = ~clk;

  // channel mux in front of each DUT: Y follows the selected channel's data
  assign y_a = en_a ? ymap[s_a] : 2'b00;
  assign y_b = en_b ? ymap[s_b] : 2'b00;

  sel_scan_ctrl #(.DWELL(4), .W(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont), .Y(y_a),
    .S(s_a), .EN(en_a), .snap(snap_a), .valid(valid_a),
`ifdef SEL_SCAN_CHG_DET_EN
    .chg(chg_a),
`endif
    .busy(busy_a)
  );

  sel_scan_ctrl #(.DWELL(1), .W(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont), .Y(y_b),
    .S(s_b), .EN(en_b), .snap(snap_b), .valid(valid_b),
`ifdef SEL_SCAN_CHG_DET_EN
    .chg(chg_b),
`endif
    .busy(busy_b)
  );

  // reference: position k counts cycles into the sweep; channel = k / dwell
  int         m_dw    [2];
  logic       m_busy  [2];
  int         m_k     [2];
  logic [7:0] m_snap  [2];
  logic [7:0] m_prev  [2];
  logic       m_valid [2];
  logic       m_chg   [2];

  initial begin
    m_dw[0] = 4;
    m_dw[1] = 1;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_k[d] = 0; m_snap[d] = '0; m_prev[d] = '0;
      m_valid[d] = 1'b0; m_chg[d] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_chg[d]   = 1'b0;
      if (rst) begin
        m_busy[d] = 1'b0; m_k[d] = 0; m_snap[d] = '0; m_prev[d] = '0;
      end else if (!m_busy[d]) begin
        if (start) begin
          m_busy[d] = 1'b1;
          m_k[d]    = 0;
        end
      end else if (abort) begin
        m_busy[d] = 1'b0;
      end else begin
        if ((m_k[d] + 1) % m_dw[d] == 0)
          m_snap[d][(m_k[d] / m_dw[d]) * 2 +: 2] = ymap[m_k[d] / m_dw[d]];
        m_k[d] = m_k[d] + 1;
        if (m_k[d] == 4 * m_dw[d]) begin
          m_valid[d] = 1'b1;
          m_chg[d]   = (m_snap[d] != m_prev[d]);
          m_prev[d]  = m_snap[d];
          m_k[d]     = 0;
          if (!cont) m_busy[d] = 1'b0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [1:0] es_a, es_b;
    es_a = m_busy[0] ? 2'(m_k[0] / m_dw[0]) : 2'd0;
    es_b = m_busy[1] ? 2'(m_k[1] / m_dw[1]) : 2'd0;
    check_eq("a_S",     32'(s_a),     32'(es_a));
    check_eq("a_EN",    32'(en_a),    32'(m_busy[0]));
    check_eq("a_busy",  32'(busy_a),  32'(m_busy[0]));
    check_eq("a_valid", 32'(valid_a), 32'(m_valid[0]));
    check_eq("a_snap",  32'(snap_a),  32'(m_snap[0]));
    check_eq("b_S",     32'(s_b),     32'(es_b));
    check_eq("b_EN",    32'(en_b),    32'(m_busy[1]));
    check_eq("b_busy",  32'(busy_b),  32'(m_busy[1]));
    check_eq("b_valid", 32'(valid_b), 32'(m_valid[1]));
    check_eq("b_snap",  32'(snap_b),  32'(m_snap[1]));
`ifdef SEL_SCAN_CHG_DET_EN
    check_eq("a_chg",   32'(chg_a),   32'(m_chg[0]));
    check_eq("b_chg",   32'(chg_b),   32'(m_chg[1]));
`endif
    if (valid_a) nval_a++;
    if (valid_b) nval_b++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int idx;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0;
    for (int i = 0; i < 4; i++) ymap[i] = 2'(i);
    tick(); tick();
    check_eq("rst_snap", 32'(snap_a), 32'h0);
    check_eq("rst_en",   32'(en_a),   32'h0);
    rst = 1'b0;

    // one-shot sweep
    start = 1'b1; tick(); start = 1'b0;
    repeat (18) tick();
    check_eq("oneshot_snap_a", 32'(snap_a), 32'hE4);
    check_eq("oneshot_snap_b", 32'(snap_b), 32'hE4);
    check_eq("oneshot_nval_a", 32'(nval_a), 32'd1);
    check_eq("oneshot_nval_b", 32'(nval_b), 32'd1);
    check_eq("oneshot_idle_a", 32'(en_a),   32'd0);

    // continuous, then drop cont mid-sweep
    cont = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (40) tick();
    cont = 1'b0;
    repeat (20) tick();
    check_eq("cont_idle_a", 32'(busy_a), 32'd0);

    // abort during channel 1
    ymap[0] = 2'd0; ymap[1] = 2'd2;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check_eq("abort_en_a", 32'(en_a), 32'd0);
    check_eq("abort_snap_a", 32'(snap_a), 32'hE4);
    repeat (3) tick();
    ymap[1] = 2'd1;

    // reset mid-sweep with start held high
    start = 1'b1; tick();
    repeat (9) tick();
    start = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    check_eq("midrst_snap_a", 32'(snap_a), 32'h0);
    check_eq("midrst_busy_a", 32'(busy_a), 32'd0);

    // two identical continuous sweeps, then channel 2 data changes
    cont = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (31) tick();
    ymap[2] = 2'd0;
    repeat (16) tick();
    cont = 1'b0;
    repeat (20) tick();
    ymap[2] = 2'd2;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) cont = ~cont;
      if ($urandom_range(0, 39) == 0) begin
        idx = int'($urandom_range(0, 3));
        ymap[idx] = 2'($urandom);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
